// File: rtl/uart_pkg.sv
// Shared constants and state encoding for the UART receiver.
// Latency: none; this package holds no logic.
// Backpressure: not applicable.
package uart_pkg;

    // Receiver FSM states
    typedef enum logic [1:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP
    } rx_state_t;

    // 16x oversampling. Start-bit validation happens at mid-bit, and each later bit
    // is sampled one full bit time after the previous sample point.
    localparam int         OVERSAMPLE       = 16;
    localparam logic [3:0] MID_SAMPLE       = 4'(OVERSAMPLE / 2 - 1);
    localparam logic [3:0] LAST_SAMPLE      = 4'(OVERSAMPLE - 1);

    // 50 MHz / (115200 * 16) ~= 27 clk per oversample tick
    localparam int         DEFAULT_TICK_DIV = 27;

endpackage

// File: rtl/uart_rx_if.sv
// Byte-side and line-side signals of the UART receiver, bundled for port hookup.
// Latency: none; this interface holds no logic.
// Backpressure: data_ready/rd handshake; an unread byte is overwritten and overrun is flagged.
interface uart_rx_if #(
    parameter int DATA_BITS = 8
);
    logic                 rx;
    logic                 rd;
    logic [DATA_BITS-1:0] data_out;
    logic                 data_ready;
    logic                 frame_err;
    logic                 overrun;
    logic                 busy;

    // The receiver drives the byte side and observes the line
    modport slave (
        input  rx,
        input  rd,
        output data_out,
        output data_ready,
        output frame_err,
        output overrun,
        output busy
    );

    // The line driver / byte consumer
    modport master (
        output rx,
        output rd,
        input  data_out,
        input  data_ready,
        input  frame_err,
        input  overrun,
        input  busy
    );
endinterface

// File: rtl/uart_rx_tickgen.sv
// Free-running divider producing the 16x oversample tick.
// Latency: tick is a one-clk pulse every TICK_DIV clks, starting TICK_DIV clks after reset.
// Backpressure: none; the counter never stalls.
module uart_rx_tickgen
    import uart_pkg::*;
#(
    parameter int TICK_DIV = DEFAULT_TICK_DIV
) (
    input  logic clk,
    input  logic reset,
    output logic tick
);
    localparam int CW = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    logic [CW-1:0] cnt;

    assign tick = (cnt == CW'(TICK_DIV - 1));

    // Count 0..TICK_DIV-1 and wrap on the tick cycle
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt <= '0;
        end else if (tick) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end
endmodule

// File: rtl/uart_rx.sv
// 8N1-style UART receiver with 16x oversampling, mid-bit sampling, LSB first.
// Latency: data_ready rises 1 clk after the stop-bit sample tick (rx passes through a 2-clk synchronizer first).
// Backpressure: none on the line; an unread byte is overwritten by the next good byte and overrun is set.
module uart_rx
    import uart_pkg::*;
#(
    parameter int TICK_DIV  = DEFAULT_TICK_DIV,
    parameter int DATA_BITS = 8
) (
    input  logic      clk,
    input  logic      reset,
    uart_rx_if.slave  bus
);
    localparam int BW = $clog2(DATA_BITS + 1);

    logic                 tick;
    logic [1:0]           sync_q;
    logic                 rxs;

    rx_state_t            state, state_nxt;
    logic [3:0]           s_cnt, s_cnt_nxt;
    logic [BW-1:0]        b_cnt, b_cnt_nxt;
    logic [DATA_BITS-1:0] shift_q, shift_nxt;
    logic [DATA_BITS-1:0] data_q, data_nxt;
    logic                 ready_q, ready_nxt;
    logic                 fe_q, fe_nxt;
    logic                 ovr_q, ovr_nxt;
    logic                 load;

    uart_rx_tickgen #(.TICK_DIV(TICK_DIV)) u_tickgen (
        .clk   (clk),
        .reset (reset),
        .tick  (tick)
    );

    // Two-flop synchronizer; resets to the idle (high) line level
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            sync_q <= 2'b11;
        end else begin
            sync_q <= {sync_q[0], bus.rx};
        end
    end

    assign rxs = sync_q[1];

    // State, counters, shift register and output flags
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state   <= ST_IDLE;
            s_cnt   <= '0;
            b_cnt   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            ready_q <= 1'b0;
            fe_q    <= 1'b0;
            ovr_q   <= 1'b0;
        end else begin
            state   <= state_nxt;
            s_cnt   <= s_cnt_nxt;
            b_cnt   <= b_cnt_nxt;
            shift_q <= shift_nxt;
            data_q  <= data_nxt;
            ready_q <= ready_nxt;
            fe_q    <= fe_nxt;
            ovr_q   <= ovr_nxt;
        end
    end

    // Frame sequencing on ticks, plus the holding-register handshake
    always_comb begin
        state_nxt = state;
        s_cnt_nxt = s_cnt;
        b_cnt_nxt = b_cnt;
        shift_nxt = shift_q;
        load      = 1'b0;
        fe_nxt    = 1'b0;

        if (tick) begin
            case (state)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_nxt = ST_START;
                        s_cnt_nxt = '0;
                    end
                end
                ST_START: begin
                    if (s_cnt == MID_SAMPLE) begin
                        // Still low at mid start bit: a real frame, otherwise a glitch
                        if (!rxs) begin
                            state_nxt = ST_DATA;
                            s_cnt_nxt = '0;
                            b_cnt_nxt = '0;
                        end else begin
                            state_nxt = ST_IDLE;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
                ST_DATA: begin
                    if (s_cnt == LAST_SAMPLE) begin
                        shift_nxt = {rxs, shift_q[DATA_BITS-1:1]};
                        s_cnt_nxt = '0;
                        if (b_cnt == BW'(DATA_BITS - 1)) begin
                            state_nxt = ST_STOP;
                        end else begin
                            b_cnt_nxt = b_cnt + 1'b1;
                        end
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
                ST_STOP: begin
                    if (s_cnt == LAST_SAMPLE) begin
                        if (rxs) begin
                            load = 1'b1;
                        end else begin
                            fe_nxt = 1'b1;
                        end
                        state_nxt = ST_IDLE;
                    end else begin
                        s_cnt_nxt = s_cnt + 4'd1;
                    end
                end
                default: state_nxt = ST_IDLE;
            endcase
        end

        data_nxt = load ? shift_q : data_q;

        // A load wins over rd; a same-clk rd simply consumes the old byte
        if (load) begin
            ready_nxt = 1'b1;
        end else if (bus.rd) begin
            ready_nxt = 1'b0;
        end else begin
            ready_nxt = ready_q;
        end

        if (load && ready_q && !bus.rd) begin
            ovr_nxt = 1'b1;
        end else if (bus.rd) begin
            ovr_nxt = 1'b0;
        end else begin
            ovr_nxt = ovr_q;
        end
    end

    assign bus.data_out   = data_q;
    assign bus.data_ready = ready_q;
    assign bus.frame_err  = fe_q;
    assign bus.overrun    = ovr_q;
    assign bus.busy       = (state != ST_IDLE);

endmodule

// File: tb/tb_uart_rx.sv
// Self-checking bench for uart_rx: frames are driven at bit level and outputs are compared
// against a byte-level model of the holding register, the flags and the frame-error count.
module tb_uart_rx;
    localparam int TD  = 4;
    localparam int BIT = 16 * TD;

    logic clk = 1'b0;
    logic reset;

    uart_rx_if #(.DATA_BITS(8)) bus ();

    uart_rx #(.TICK_DIV(TD), .DATA_BITS(8)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Pulse monitors, sampled away from the active edge
    int   fe_high = 0;
    int   fe_rise = 0;
    int   dr_rise = 0;
    int   dr_rise_cyc = 0;
    logic fe_prev = 1'b0;
    logic dr_prev = 1'b0;
    always @(negedge clk) begin
        if (bus.frame_err) fe_high++;
        if (bus.frame_err && !fe_prev) fe_rise++;
        fe_prev = bus.frame_err;
        if (bus.data_ready && !dr_prev) begin
            dr_rise++;
            dr_rise_cyc = cyc;
        end
        dr_prev = bus.data_ready;
    end

    int n_tests = 0;
    int n_fail  = 0;

    // Reference model: what the consumer should see after whole frames and reads
    logic [7:0] m_data;
    logic       m_ready;
    logic       m_ovr;
    int         m_fe;

    task automatic model_reset();
        m_data  = 8'h00;
        m_ready = 1'b0;
        m_ovr   = 1'b0;
        m_fe    = 0;
    endtask

    // One complete frame; rd_same means a read lands on the same clk as the store
    task automatic model_frame(input logic [7:0] b, input logic stop_ok, input logic rd_same);
        if (!stop_ok) begin
            m_fe++;
        end else begin
            if (m_ready && !rd_same) m_ovr = 1'b1;
            else if (rd_same) m_ovr = 1'b0;
            m_data  = b;
            m_ready = 1'b1;
        end
    endtask

    task automatic model_rd();
        m_ready = 1'b0;
        m_ovr   = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Drive one frame at bit level, LSB first, then gap_bits of idle line
    task automatic send_frame(input logic [7:0] b, input logic stop_bit, input int gap_bits);
        bus.rx = 1'b0;
        idle(BIT);
        for (int i = 0; i < 8; i++) begin
            bus.rx = b[i];
            idle(BIT);
        end
        bus.rx = stop_bit;
        idle(BIT);
        bus.rx = 1'b1;
        idle(gap_bits * BIT);
    endtask

    task automatic pulse_rd();
        bus.rd = 1'b1;
        @(negedge clk);
        bus.rd = 1'b0;
        model_rd();
    endtask

    task automatic test_reset();
        reset  = 1'b1;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        model_reset();
        idle(3);
        n_tests++;
        if (bus.data_out !== 8'h00) begin n_fail++; $display("FAIL reset_data_out: got %h expected 00", bus.data_out); end
        n_tests++;
        if ({bus.data_ready, bus.frame_err, bus.overrun, bus.busy} !== 4'b0000) begin
            n_fail++;
            $display("FAIL reset_flags: got rdy/fe/ovr/busy=%b expected 0000",
                     {bus.data_ready, bus.frame_err, bus.overrun, bus.busy});
        end
        reset = 1'b0;
        idle(2 * BIT);
    endtask

    task automatic test_basic();
        int start_cyc, r0, lat;
        r0        = dr_rise;
        start_cyc = cyc;
        send_frame(8'hA5, 1'b1, 1);
        model_frame(8'hA5, 1'b1, 1'b0);
        lat = dr_rise_cyc - start_cyc;
        n_tests++;
        if (bus.data_out !== m_data) begin n_fail++; $display("FAIL basic_data: got %h expected %h", bus.data_out, m_data); end
        n_tests++;
        if ({bus.data_ready, bus.frame_err, bus.overrun} !== {m_ready, 1'b0, m_ovr}) begin
            n_fail++;
            $display("FAIL basic_flags: got rdy/fe/ovr=%b expected %b",
                     {bus.data_ready, bus.frame_err, bus.overrun}, {m_ready, 1'b0, m_ovr});
        end
        n_tests++;
        if (dr_rise - r0 != 1 || lat < 152 * TD + 2 || lat > 152 * TD + TD + 3) begin
            n_fail++;
            $display("FAIL basic_latency: got %0d rises at %0d clk expected 1 rise in [%0d,%0d]",
                     dr_rise - r0, lat, 152 * TD + 2, 152 * TD + TD + 3);
        end
        pulse_rd();
        n_tests++;
        if (bus.data_ready !== m_ready || bus.data_out !== m_data) begin
            n_fail++;
            $display("FAIL basic_rd: got rdy=%b data=%h expected rdy=%b data=%h",
                     bus.data_ready, bus.data_out, m_ready, m_data);
        end
    endtask

    task automatic test_glitch();
        int fr0;
        fr0    = fe_rise;
        bus.rx = 1'b0;
        idle(4 * TD);
        bus.rx = 1'b1;
        idle(TD);
        n_tests++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL glitch_busy_start: got %b expected 1", bus.busy); end
        idle(2 * BIT);
        n_tests++;
        if ({bus.busy, bus.data_ready} !== {1'b0, m_ready} || fe_rise != fr0) begin
            n_fail++;
            $display("FAIL glitch_idle: got busy=%b rdy=%b fe=%0d expected busy=0 rdy=%b fe=0",
                     bus.busy, bus.data_ready, fe_rise - fr0, m_ready);
        end
    endtask

    task automatic test_frame_err();
        int fr0, fh0;
        fr0 = fe_rise;
        fh0 = fe_high;
        send_frame(8'h3C, 1'b0, 1);
        model_frame(8'h3C, 1'b0, 1'b0);
        n_tests++;
        if (fe_rise - fr0 != 1 || fe_high - fh0 != 1) begin
            n_fail++;
            $display("FAIL ferr_pulse: got %0d pulses %0d clks expected 1 pulse 1 clk", fe_rise - fr0, fe_high - fh0);
        end
        n_tests++;
        if (bus.data_ready !== m_ready || bus.data_out !== m_data || bus.busy !== 1'b0) begin
            n_fail++;
            $display("FAIL ferr_hold: got rdy=%b data=%h busy=%b expected rdy=%b data=%h busy=0",
                     bus.data_ready, bus.data_out, bus.busy, m_ready, m_data);
        end
    endtask

    task automatic test_back_to_back();
        send_frame(8'h11, 1'b1, 0);
        model_frame(8'h11, 1'b1, 1'b0);
        send_frame(8'h22, 1'b1, 1);
        model_frame(8'h22, 1'b1, 1'b0);
        n_tests++;
        if ({bus.data_out, bus.data_ready, bus.overrun} !== {m_data, m_ready, m_ovr}) begin
            n_fail++;
            $display("FAIL b2b_overrun: got data=%h rdy=%b ovr=%b expected data=%h rdy=%b ovr=%b",
                     bus.data_out, bus.data_ready, bus.overrun, m_data, m_ready, m_ovr);
        end
        pulse_rd();
        n_tests++;
        if ({bus.data_ready, bus.overrun} !== {m_ready, m_ovr}) begin
            n_fail++;
            $display("FAIL b2b_rd_clear: got rdy=%b ovr=%b expected rdy=%b ovr=%b",
                     bus.data_ready, bus.overrun, m_ready, m_ovr);
        end
    endtask

    // Frames start exactly 10 bit times apart and the tick period divides a bit time,
    // so the second store lands exactly 10*BIT clks after the first.
    task automatic test_rd_on_load();
        logic timed_out;
        logic [7:0] pre_data, post_data;
        logic pre_rdy;
        int   l2;
        timed_out = 1'b0;
        pre_data  = 8'h00;
        post_data = 8'h00;
        pre_rdy   = 1'b0;
        fork
            begin
                send_frame(8'h11, 1'b1, 0);
                send_frame(8'h22, 1'b1, 1);
            end
            begin
                int n;
                n = 0;
                while (bus.data_ready !== 1'b1 && n < 12 * BIT) begin
                    @(negedge clk);
                    n++;
                end
                if (n >= 12 * BIT) begin
                    timed_out = 1'b1;
                end else begin
                    l2 = cyc + 10 * BIT;
                    n = 0;
                    while (cyc < l2 - 1 && n < 12 * BIT) begin
                        @(negedge clk);
                        n++;
                    end
                    pre_data = bus.data_out;
                    pre_rdy  = bus.data_ready;
                    bus.rd   = 1'b1;
                    @(negedge clk);
                    bus.rd    = 1'b0;
                    post_data = bus.data_out;
                end
            end
        join
        model_frame(8'h11, 1'b1, 1'b0);
        model_frame(8'h22, 1'b1, 1'b1);
        n_tests++;
        if (timed_out) begin n_fail++; $display("FAIL rdload_timeout: got no data_ready expected one within %0d clk", 12 * BIT); end
        n_tests++;
        if (pre_data !== 8'h11 || pre_rdy !== 1'b1 || post_data !== 8'h22) begin
            n_fail++;
            $display("FAIL rdload_align: got pre=%h/%b post=%h expected pre=11/1 post=22", pre_data, pre_rdy, post_data);
        end
        n_tests++;
        if ({bus.data_out, bus.data_ready, bus.overrun} !== {m_data, m_ready, m_ovr}) begin
            n_fail++;
            $display("FAIL rdload_result: got data=%h rdy=%b ovr=%b expected data=%h rdy=%b ovr=%b",
                     bus.data_out, bus.data_ready, bus.overrun, m_data, m_ready, m_ovr);
        end
    endtask

    task automatic test_random();
        for (int k = 0; k < 12; k++) begin
            logic [7:0] b;
            logic       ok;
            int         fr0;
            b   = 8'($urandom_range(0, 255));
            ok  = ($urandom_range(0, 5) != 0);
            fr0 = fe_rise;
            if ($urandom_range(0, 1) == 1) pulse_rd();
            send_frame(b, ok, $urandom_range(1, 2));
            model_frame(b, ok, 1'b0);
            n_tests++;
            if ({bus.data_out, bus.data_ready, bus.overrun} !== {m_data, m_ready, m_ovr} ||
                fe_rise - fr0 != (ok ? 0 : 1)) begin
                n_fail++;
                $display("FAIL random_%0d: got data=%h rdy=%b ovr=%b fe=%0d expected data=%h rdy=%b ovr=%b fe=%0d",
                         k, bus.data_out, bus.data_ready, bus.overrun, fe_rise - fr0,
                         m_data, m_ready, m_ovr, ok ? 0 : 1);
            end
        end
    endtask

    task automatic test_reset_mid_frame();
        send_frame(8'hC3, 1'b1, 1);
        model_frame(8'hC3, 1'b1, 1'b0);
        // start bit, then 0xFF data ones up to the middle of data bit 4
        bus.rx = 1'b0;
        idle(BIT);
        bus.rx = 1'b1;
        idle(4 * BIT + BIT / 2);
        n_tests++;
        if (bus.busy !== 1'b1) begin n_fail++; $display("FAIL midreset_busy_before: got %b expected 1", bus.busy); end
        #2 reset = 1'b1;
        #1;
        model_reset();
        n_tests++;
        if ({bus.data_out, bus.data_ready, bus.frame_err, bus.overrun, bus.busy} !== 12'h000) begin
            n_fail++;
            $display("FAIL midreset_async: got data=%h rdy/fe/ovr/busy=%b expected 00 0000",
                     bus.data_out, {bus.data_ready, bus.frame_err, bus.overrun, bus.busy});
        end
        @(negedge clk);
        idle(2);
        reset = 1'b0;
        idle(2 * BIT);
        n_tests++;
        if ({bus.data_ready, bus.busy} !== 2'b00) begin
            n_fail++;
            $display("FAIL midreset_discard: got rdy=%b busy=%b expected 0 0", bus.data_ready, bus.busy);
        end
        send_frame(8'h5A, 1'b1, 1);
        model_frame(8'h5A, 1'b1, 1'b0);
        n_tests++;
        if ({bus.data_out, bus.data_ready, bus.overrun} !== {m_data, m_ready, m_ovr}) begin
            n_fail++;
            $display("FAIL midreset_next: got data=%h rdy=%b ovr=%b expected data=%h rdy=%b ovr=%b",
                     bus.data_out, bus.data_ready, bus.overrun, m_data, m_ready, m_ovr);
        end
    endtask

    initial begin
        reset  = 1'b1;
        bus.rx = 1'b1;
        bus.rd = 1'b0;
        @(negedge clk);
        test_reset();
        test_basic();
        test_glitch();
        test_frame_err();
        test_back_to_back();
        test_rd_on_load();
        pulse_rd();
        test_random();
        test_reset_mid_frame();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Serial UART receiver; the receive-side counterpart of the team's 8N1 UART transmit FSM.
- Accepts an asynchronous serial line, oversamples it 16x, validates the start bit and samples data bits mid-bit, LSB first.
- Checks the stop bit and presents each byte in a holding register with ready/read handshake, framing-error and overrun flags.
- Sits between the pad-side rx line and the byte consumer (loopback checker / host logic).

Parameters:
- TICK_DIV, 27, clk cycles per 16x oversample tick (50 MHz / (115200*16) ≈ 27); legal range ≥2.
- DATA_BITS, 8, data bits per frame; no parity; 1 stop bit.

Ports:
- clk  input  1  system clock
- reset  input  1  reset, asynchronous, active-high
- rx  input  1  serial line, idle high, asynchronous to clk
- rd  input  1  consumer read strobe, one clk; clears data_ready
- data_out  output  DATA_BITS  last good received byte
- data_ready  output  1  high while data_out holds unread byte
- frame_err  output  1  one-clk pulse: stop bit sampled low
- overrun  output  1  sticky; set when a good byte is lost to an unread previous byte; cleared by rd
- busy  output  1  high in any state other than IDLE

Behaviour:
- Reset (async, any time incl. mid-frame): state IDLE, counters 0, synchronizer stages 1, data_out 0, data_ready 0, frame_err 0, overrun 0, busy 0. Reset mid-frame discards the partial byte.
- rx passes through 2-flop synchronizer (reset to 1); all decisions use the synced value rxs (2-clk latency).
- Tick generator: free-running counter 0..TICK_DIV-1; tick is a one-clk pulse on wrap; counter reset to 0.
- Sample counter s_cnt (4 bits) and bit counter b_cnt advance only on tick cycles.
- FSM:
  - IDLE: on tick with rxs=0 -> START, s_cnt=0.
  - START: on tick s_cnt++; at s_cnt==7, if rxs=0 -> DATA, s_cnt=0, b_cnt=0; else -> IDLE (glitch rejected, no flags).
  - DATA: on tick s_cnt++; at s_cnt==15, shift rxs into shift reg MSB side (LSB-first frame), b_cnt++; after bit DATA_BITS-1 -> STOP, s_cnt=0.
  - STOP: at s_cnt==15 sample rxs; if 1, load data_out from shift reg, data_ready=1; if 0, frame_err pulse, data_out/data_ready unchanged. Either way -> IDLE.
- A break (rx held low) after a frame error re-enters START only after IDLE sees rxs=0 on a tick; a held-low line produces repeated frame_err per frame time.
- Handshake: rd with data_ready=1 clears data_ready next clk; rd with data_ready=0 is ignored, except it still clears overrun.
- Simultaneous good-stop load and rd in the same clk: new byte loaded, data_ready stays 1, no overrun.
- Good-stop load while data_ready=1 and no rd: data_out overwritten with new byte, overrun set.
- Good byte latency: data_ready rises 1 clk after the stop-bit mid-sample tick.

Decomposition:
- Shared package uart_pkg: state encoding (IDLE, START, DATA, STOP), OVERSAMPLE=16, MID_SAMPLE=7, LAST_SAMPLE=15, default TICK_DIV.
- One sub-module: uart_rx_tickgen (parameter TICK_DIV; ports clk, reset, tick). Synchronizer, FSM, shift reg and flags stay in uart_rx.

Test Plan:
- Byte 0xA5 sent 8N1 at tick*16 per bit -> data_out=0xA5, data_ready=1, frame_err=0, overrun=0; rd -> data_ready=0 next clk.
- Low glitch of 4 ticks on idle line -> returns to IDLE, busy drops, no data_ready, no frame_err.
- Frame 0x3C with stop bit driven 0 -> frame_err single-clk pulse, data_ready stays 0, data_out unchanged.
- Back-to-back 0x11 then 0x22, no rd -> data_out=0x22, data_ready=1, overrun=1; rd clears both flags.
- rd asserted on the exact clk of the second byte's load -> data_out=0x22, data_ready=1, overrun=0.
- reset asserted during DATA bit 4 of 0xFF -> all outputs 0 immediately; following 0x5A received correctly.
